io_port_hub: RTL and testbench

Parametrised multi-channel I/O port block for the Mini-SRC system, replacing the single inport/outport register pair. It provides NUM_CH input and NUM_CH output channels, each buffered by its own FIFO with valid/ready handshakes on the external side. On the processor side it exposes a port-select plus read/write strobes driven by the control unit, and returns data onto the datapath bus. Per-channel status and sticky overflow/underflow flags are visible to software.

---
 rtl/io_port_hub_pkg.sv | 25 ++
 rtl/io_fifo.sv | 56 +++++
 rtl/io_port_hub.sv | 122 ++++++++++++
 tb/tb_io_port_hub.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_hub_pkg.sv
// Shared constants and helpers for io_port_hub.
// Default parameter values, channel-select width and status/error bit mapping.
// Pure definitions only; no logic and no flow control.
package io_port_hub_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    // Width of the CPU channel select; a single channel still gets a 1-bit select.
    function automatic int ch_sel_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Status and error vectors interleave input/output per channel:
    // even bit = input-side flag, odd bit = output-side flag.
    function automatic int in_bit_idx(input int ch);
        return 2 * ch;
    endfunction

    function automatic int out_bit_idx(input int ch);
        return 2 * ch + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous show-ahead FIFO: head is the oldest word, forced to 0 when empty.
// Latency: a word pushed at edge N is visible on head after edge N.
// Backpressure: push ignored while full, pop ignored while empty; both sampled before the edge.
//
// Ports: clk, reset (async active-low), push/push_data, pop, head, full, empty.
module io_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // One extra MSB on each pointer separates full (MSBs differ) from empty (MSBs equal).
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: empty pointers mask stale contents from head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/io_port_hub.sv
// Multi-channel CPU I/O port hub: NUM_CH input FIFOs and NUM_CH output FIFOs.
// Latency: 1 cycle ext-in -> out_inport_data, 1 cycle CPU write -> ext_out_valid.
// Backpressure: ext_in_ready = input FIFO not full; CPU pops/pushes on empty/full are dropped and flagged.
//
// Ports: clk, reset (async active-low); CPU side in_port_sel, in_inport_read, in_outport_write,
// in_bus, in_clear_err, out_inport_data, out_status, out_err; external side ext_in_* and ext_out_*
// (channel i at bits [i*DATA_W +: DATA_W]).
// Build option IO_PORT_HUB_IRQ_EN adds in_irq_mask and a registered out_irq.
module io_port_hub
    import io_port_hub_pkg::*;
#(
    parameter  int DATA_W     = DEF_DATA_W,
    parameter  int NUM_CH     = DEF_NUM_CH,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int CH_SEL_W   = ch_sel_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CH_SEL_W-1:0]      in_port_sel,
    input  logic                     in_inport_read,
    input  logic                     in_outport_write,
    input  logic [DATA_W-1:0]        in_bus,
    input  logic                     in_clear_err,
    output logic [DATA_W-1:0]        out_inport_data,
    output logic [2*NUM_CH-1:0]      out_status,
    output logic [2*NUM_CH-1:0]      out_err,
`ifdef IO_PORT_HUB_IRQ_EN
    input  logic [NUM_CH-1:0]        in_irq_mask,
    output logic                     out_irq,
`endif
    input  logic [NUM_CH*DATA_W-1:0] ext_in_data,
    input  logic [NUM_CH-1:0]        ext_in_valid,
    output logic [NUM_CH-1:0]        ext_in_ready,
    output logic [NUM_CH*DATA_W-1:0] ext_out_data,
    output logic [NUM_CH-1:0]        ext_out_valid,
    input  logic [NUM_CH-1:0]        ext_out_ready
);

    logic                sel_ok;
    logic [DATA_W-1:0]   in_head [NUM_CH];
    logic [NUM_CH-1:0]   in_full;
    logic [NUM_CH-1:0]   in_empty;
    logic [NUM_CH-1:0]   out_full;
    logic [NUM_CH-1:0]   out_empty;
    logic [2*NUM_CH-1:0] err_evt;
    logic [2*NUM_CH-1:0] err_q;

    // Out-of-range selects (possible when NUM_CH is not a power of two) are inert.
    assign sel_ok = (int'(in_port_sel) < NUM_CH);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic sel_hit;
        assign sel_hit = sel_ok && (int'(in_port_sel) == ch);

        io_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_in_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (ext_in_valid[ch]),
            .push_data (ext_in_data[ch*DATA_W +: DATA_W]),
            .pop       (in_inport_read && sel_hit),
            .head      (in_head[ch]),
            .full      (in_full[ch]),
            .empty     (in_empty[ch])
        );

        io_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_out_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_outport_write && sel_hit),
            .push_data (in_bus),
            .pop       (ext_out_ready[ch]),
            .head      (ext_out_data[ch*DATA_W +: DATA_W]),
            .full      (out_full[ch]),
            .empty     (out_empty[ch])
        );

        assign out_status[in_bit_idx(ch)]  = !in_empty[ch];
        assign out_status[out_bit_idx(ch)] = out_full[ch];
        assign err_evt[in_bit_idx(ch)]     = in_inport_read && sel_hit && in_empty[ch];
        assign err_evt[out_bit_idx(ch)]    = in_outport_write && sel_hit && out_full[ch];
    end

    assign ext_in_ready  = ~in_full;
    assign ext_out_valid = ~out_empty;
    assign out_err       = err_q;

    // Show-ahead read mux; FIFO heads are already zero when empty.
    always_comb begin
        out_inport_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_ok && (int'(in_port_sel) == i)) begin
                out_inport_data = in_head[i];
            end
        end
    end

    // Sticky errors: a new event in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= (in_clear_err ? '0 : err_q) | err_evt;
        end
    end

`ifdef IO_PORT_HUB_IRQ_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_irq <= 1'b0;
        end else begin
            out_irq <= (|(~in_empty & in_irq_mask)) || (|err_q);
        end
    end
`endif

endmodule

// File: tb/tb_io_port_hub.sv
`timescale 1ns/1ps
module tb_io_port_hub;

    localparam int DW    = 32;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [0:0]          in_port_sel;
    logic                in_inport_read;
    logic                in_outport_write;
    logic [DW-1:0]       in_bus;
    logic                in_clear_err;
    logic [DW-1:0]       out_inport_data;
    logic [2*NCH-1:0]    out_status;
    logic [2*NCH-1:0]    out_err;
    logic [NCH*DW-1:0]   ext_in_data;
    logic [NCH-1:0]      ext_in_valid;
    logic [NCH-1:0]      ext_in_ready;
    logic [NCH*DW-1:0]   ext_out_data;
    logic [NCH-1:0]      ext_out_valid;
    logic [NCH-1:0]      ext_out_ready;
`ifdef IO_PORT_HUB_IRQ_EN
    logic [NCH-1:0]      in_irq_mask = '0;
    logic                out_irq;
`endif

    always #5 clk = ~clk;

    io_port_hub #(
        .DATA_W     (DW),
        .NUM_CH     (NCH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_port_sel      (in_port_sel),
        .in_inport_read   (in_inport_read),
        .in_outport_write (in_outport_write),
        .in_bus           (in_bus),
        .in_clear_err     (in_clear_err),
        .out_inport_data  (out_inport_data),
        .out_status       (out_status),
        .out_err          (out_err),
`ifdef IO_PORT_HUB_IRQ_EN
        .in_irq_mask      (in_irq_mask),
        .out_irq          (out_irq),
`endif
        .ext_in_data      (ext_in_data),
        .ext_in_valid     (ext_in_valid),
        .ext_in_ready     (ext_in_ready),
        .ext_out_data     (ext_out_data),
        .ext_out_valid    (ext_out_valid),
        .ext_out_ready    (ext_out_ready)
    );

    // Reference model: plain queues of words and occupancy counts.
    logic [DW-1:0]    in_q    [NCH][$];
    logic [DW-1:0]    exp_out [NCH][$];
    logic [DW-1:0]    cpu_exp [$];
    int               out_cnt [NCH];
    logic [2*NCH-1:0] m_err;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        logic [2*NCH-1:0] st;
        logic [NCH-1:0]   rdy;
        logic [NCH-1:0]   vld;
        for (int i = 0; i < NCH; i++) begin
            st[2*i]   = (in_q[i].size() > 0);
            st[2*i+1] = (out_cnt[i] == DEPTH);
            rdy[i]    = (in_q[i].size() < DEPTH);
            vld[i]    = (out_cnt[i] > 0);
        end
        chk({tag, " status"},    64'(out_status),    64'(st));
        chk({tag, " err"},       64'(out_err),       64'(m_err));
        chk({tag, " in_ready"},  64'(ext_in_ready),  64'(rdy));
        chk({tag, " out_valid"}, 64'(ext_out_valid), 64'(vld));
    endtask

    // Called just after a rising edge: drive one cycle of inputs, advance the
    // model to the next edge, then check state-level outputs after that edge.
    task automatic step(input logic [NCH-1:0] iv, input logic [NCH*DW-1:0] idat,
                        input logic [NCH-1:0] ordy, input logic sel, input logic rd,
                        input logic wr, input logic [DW-1:0] bus, input logic clr,
                        input string tag);
        logic [2*NCH-1:0] evt;
        int in_sz;
        int oc;
        evt              = '0;
        ext_in_valid     = iv;
        ext_in_data      = idat;
        ext_out_ready    = ordy;
        in_port_sel      = sel;
        in_inport_read   = rd;
        in_outport_write = wr;
        in_bus           = bus;
        in_clear_err     = clr;
        for (int i = 0; i < NCH; i++) begin
            in_sz = in_q[i].size();
            oc    = out_cnt[i];
            if (rd && (sel == i)) begin
                if (in_sz > 0) begin
                    cpu_exp.push_back(in_q[i].pop_front());
                end else begin
                    cpu_exp.push_back('0);
                    evt[2*i] = 1'b1;
                end
            end
            if (iv[i] && (in_sz < DEPTH)) begin
                in_q[i].push_back(idat[i*DW +: DW]);
            end
            if (wr && (sel == i)) begin
                if (oc < DEPTH) begin
                    exp_out[i].push_back(bus);
                    out_cnt[i]++;
                end else begin
                    evt[2*i+1] = 1'b1;
                end
            end
            if (ordy[i] && (oc > 0)) begin
                out_cnt[i]--;
            end
        end
        m_err = (clr ? '0 : m_err) | evt;
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic idle(input logic [NCH-1:0] ordy, input string tag);
        step('0, '0, ordy, 1'b0, 1'b0, 1'b0, '0, 1'b0, tag);
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        ext_in_valid     = '0;
        ext_in_data      = '0;
        ext_out_ready    = '0;
        in_port_sel      = '0;
        in_inport_read   = 1'b0;
        in_outport_write = 1'b0;
        in_bus           = '0;
        in_clear_err     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            in_q[i].delete();
            exp_out[i].delete();
            out_cnt[i] = 0;
        end
        cpu_exp.delete();
        m_err = '0;
        #1;
        check_state("reset");
        chk("reset out_data", 64'(ext_out_data), 64'(0));
        chk("reset inport_data", 64'(out_inport_data), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");
    endtask

    // Monitor: consumes expectations whenever the DUT presents data.
    always @(negedge clk) begin
        if (reset) begin
            if (in_inport_read) begin
                if (cpu_exp.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL cpu_read: read strobe with no expected word at %0t", $time);
                end else begin
                    chk("cpu_read", 64'(out_inport_data), 64'(cpu_exp.pop_front()));
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (ext_out_valid[i] && ext_out_ready[i]) begin
                    if (exp_out[i].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL ext_out ch%0d: got %h expected no word at %0t",
                                 i, ext_out_data[i*DW +: DW], $time);
                    end else begin
                        chk($sformatf("ext_out ch%0d", i), 64'(ext_out_data[i*DW +: DW]),
                            64'(exp_out[i].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        #2;
        do_reset();

        // Fill input ch1 to full, try one more, then drain through CPU reads.
        for (int k = 1; k <= 4; k++) begin
            step(2'b10, {32'hA5A5_0000 + 32'(k), 32'h0}, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "fill_in1");
        end
        step(2'b10, {32'hDEAD_BEEF, 32'h0}, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, "in1_full");
        for (int k = 0; k < 4; k++) begin
            step('0, '0, '0, 1'b1, 1'b1, 1'b0, '0, 1'b0, "read_in1");
        end

        // Five CPU writes to blocked output ch0: fifth is dropped and flagged.
        for (int k = 1; k <= 5; k++) begin
            step('0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h0000_1000 + 32'(k), 1'b0, "write_out0");
        end
        for (int k = 0; k < 6; k++) begin
            idle(2'b01, "drain_out0");
        end
        chk("drain_out0 left", 64'(exp_out[0].size()), 64'(0));

        // Underflow on empty ch0, then clear.
        step('0, '0, '0, 1'b0, 1'b1, 1'b0, '0, 1'b0, "underflow0");
        step('0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b1, "clear_err");

        // Pointer wrap on output ch1 with simultaneous push/pop.
        step('0, '0, '0, 1'b1, 1'b0, 1'b1, 32'h0000_2000, 1'b0, "wrap_prime");
        for (int k = 1; k <= 10; k++) begin
            step('0, '0, 2'b10, 1'b1, 1'b0, 1'b1, 32'h0000_2000 + 32'(k), 1'b0, "wrap");
        end
        idle(2'b10, "wrap_drain");
        idle(2'b10, "wrap_drain");
        chk("wrap left", 64'(exp_out[1].size()), 64'(0));

        // Randomised traffic with a reset in the middle.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                do_reset();
            end
            step(NCH'($urandom), {$urandom, $urandom}, NCH'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                 1'($urandom), ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 50),
                 $urandom, ($urandom_range(0, 99) < 5), "random");
        end

        for (int k = 0; k < 8; k++) begin
            idle('1, "final_drain");
        end
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("final left ch%0d", i), 64'(exp_out[i].size()), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
